pkt_ingress_arbiter: RTL

- Store-and-forward, packet-granular round-robin arbiter.
- Merges NUM_PORTS independent 134b packet streams into the single stream that feeds the PHV generator / conf parser.
- Supplies the source port number alongside each packet.
- Each port has a private word buffer with rollback, so a truncated or overflowing packet is dropped whole and never reaches the parser.

---
 rtl/pkt_ingress_arbiter.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_ingress_arbiter.sv
// Store-and-forward round-robin merge of NUM_PORTS 134b packet streams.
// Each port buffers whole packets and rolls back on truncation or overflow.
module pkt_ingress_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 6,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_PORTS-1:0]     i_pkt_valid,
  input  logic [NUM_PORTS*134-1:0] i_pkt,
  output logic                     o_pkt_valid,
  output logic [133:0]             o_pkt,
  output logic [7:0]               o_inport,
  output logic [NUM_PORTS-1:0]     o_drop,
  output logic [4*NUM_PORTS-1:0]   o_pkt_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_PKT  = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  logic [PW-1:0]        wptr_q   [NUM_PORTS];
  logic [PW-1:0]        wptr_d   [NUM_PORTS];
  logic [PW-1:0]        commit_q [NUM_PORTS];
  logic [PW-1:0]        commit_d [NUM_PORTS];
  logic [PW-1:0]        rptr_q   [NUM_PORTS];
  logic [PW-1:0]        rptr_d   [NUM_PORTS];
  logic [PW-1:0]        pkt_num_q[NUM_PORTS];
  logic [PW-1:0]        pkt_num_d[NUM_PORTS];
  logic [1:0]           wst_q    [NUM_PORTS];
  logic [1:0]           wst_d    [NUM_PORTS];
  logic [3:0]           cnt_q    [NUM_PORTS];
  logic [3:0]           cnt_d    [NUM_PORTS];
  logic [ADDR_W-1:0]    waddr_c  [NUM_PORTS];
  logic [133:0]         rd_word  [NUM_PORTS];

  logic [NUM_PORTS-1:0] we_c;
  logic [NUM_PORTS-1:0] commit_c;
  logic [NUM_PORTS-1:0] send_done_c;
  logic [NUM_PORTS-1:0] tail_at_rptr;
  logic [NUM_PORTS-1:0] drop_d;
  logic [NUM_PORTS-1:0] drop_q;

  logic [1:0]   st_q, st_d;
  logic [2:0]   grant_q, grant_d;
  logic [2:0]   rr_q, rr_d;
  logic [2:0]   gap_q, gap_d;
  logic [2:0]   rd_port_q, rd_port_d;
  logic         rd_vld_q, rd_vld_d;
  logic         o_valid_q, o_valid_d;
  logic [133:0] o_pkt_q, o_pkt_d;
  logic [7:0]   o_inport_q, o_inport_d;

  // Per-port word buffer. Tail flags sit beside it with an unregistered read
  // so the scheduler knows it is issuing the last word and can stop there.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [133:0]     mem [DEPTH];
      logic [DEPTH-1:0] tail_flag;
      logic [133:0]     rd_q;

      always_ff @(posedge i_clk) begin
        if (we_c[gi]) begin
          mem[waddr_c[gi]]       <= i_pkt[134*gi +: 134];
          tail_flag[waddr_c[gi]] <= i_pkt[134*gi + 133];
        end
        rd_q <= mem[rptr_q[gi][ADDR_W-1:0]];
      end

      assign rd_word[gi]          = rd_q;
      assign tail_at_rptr[gi]     = tail_flag[rptr_q[gi][ADDR_W-1:0]];
      assign o_pkt_cnt[4*gi +: 4] = cnt_q[gi];
    end
  endgenerate

  // Write side: a head arriving mid-packet first rolls back to the last commit.
  always_comb begin
    logic [1:0]    tag;
    logic [1:0]    st;
    logic [PW-1:0] wbase;
    logic [PW-1:0] occ;
    tag   = 2'b00;
    st    = WR_IDLE;
    wbase = '0;
    occ   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wptr_d[p]   = wptr_q[p];
      commit_d[p] = commit_q[p];
      wst_d[p]    = wst_q[p];
      waddr_c[p]  = wptr_q[p][ADDR_W-1:0];
      we_c[p]     = 1'b0;
      drop_d[p]   = 1'b0;
      commit_c[p] = 1'b0;
      tag         = i_pkt[134*p + 132 +: 2];
      st          = wst_q[p];
      wbase       = wptr_q[p];
      if (i_pkt_valid[p]) begin
        if (tag[0]) begin
          if (st == WR_PKT) begin
            wbase     = commit_q[p];
            drop_d[p] = 1'b1;
          end
          st = WR_IDLE;
        end
        occ        = wbase - rptr_q[p];
        waddr_c[p] = wbase[ADDR_W-1:0];
        wptr_d[p]  = wbase;
        wst_d[p]   = st;
        case (st)
          WR_IDLE: begin
            if (!tag[0]) begin
              drop_d[p] = 1'b1;
            end else if (occ[ADDR_W]) begin
              drop_d[p] = 1'b1;
              wst_d[p]  = tag[1] ? WR_IDLE : WR_DROP;
            end else begin
              we_c[p]   = 1'b1;
              wptr_d[p] = wbase + 1'b1;
              if (tag[1]) begin
                commit_d[p] = wbase + 1'b1;
                commit_c[p] = 1'b1;
                wst_d[p]    = WR_IDLE;
              end else begin
                wst_d[p] = WR_PKT;
              end
            end
          end
          WR_PKT: begin
            if (occ[ADDR_W]) begin
              drop_d[p] = 1'b1;
              wptr_d[p] = commit_q[p];
              wst_d[p]  = tag[1] ? WR_IDLE : WR_DROP;
            end else begin
              we_c[p]   = 1'b1;
              wptr_d[p] = wbase + 1'b1;
              if (tag[1]) begin
                commit_d[p] = wbase + 1'b1;
                commit_c[p] = 1'b1;
                wst_d[p]    = WR_IDLE;
              end
            end
          end
          default: begin
            if (tag == TAG_TAIL) wst_d[p] = WR_IDLE;
          end
        endcase
      end
    end
  end

  // Scheduler: rptr advances as each read is issued; data lands one cycle later.
  always_comb begin
    int   idx;
    int   pick;
    logic found;
    idx         = 0;
    pick        = 0;
    found       = 1'b0;
    st_d        = st_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    rd_vld_d    = 1'b0;
    rd_port_d   = rd_port_q;
    send_done_c = '0;
    for (int p = 0; p < NUM_PORTS; p++) rptr_d[p] = rptr_q[p];
    case (st_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          idx = int'(rr_q) + i;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && p == idx && pkt_num_q[p] != '0) begin
              found = 1'b1;
              pick  = p;
            end
          end
        end
        if (found) begin
          grant_d = 3'(pick);
          rr_d    = (pick == NUM_PORTS - 1) ? 3'd0 : 3'(pick + 1);
          st_d    = S_SEND;
        end
      end
      S_SEND: begin
        rd_vld_d  = 1'b1;
        rd_port_d = grant_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (grant_q == 3'(p)) begin
            rptr_d[p] = rptr_q[p] + 1'b1;
            if (tail_at_rptr[p]) begin
              send_done_c[p] = 1'b1;
              st_d           = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
              gap_d          = 3'd0;
            end
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 3'd1;
        if (gap_q == GAP_LAST) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pkt_num_d[p] = pkt_num_q[p];
      if (commit_c[p] && !send_done_c[p]) pkt_num_d[p] = pkt_num_q[p] + 1'b1;
      else if (!commit_c[p] && send_done_c[p]) pkt_num_d[p] = pkt_num_q[p] - 1'b1;
      cnt_d[p] = cnt_q[p];
      if (commit_c[p] && cnt_q[p] != 4'hf) cnt_d[p] = cnt_q[p] + 4'd1;
    end
  end

  always_comb begin
    o_valid_d  = rd_vld_q;
    o_pkt_d    = '0;
    o_inport_d = o_inport_q;
    if (rd_vld_q) begin
      o_inport_d = {5'b0, rd_port_q};
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_port_q == 3'(p)) o_pkt_d = rd_word[p];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wptr_q[p]    <= '0;
        commit_q[p]  <= '0;
        rptr_q[p]    <= '0;
        pkt_num_q[p] <= '0;
        wst_q[p]     <= WR_IDLE;
        cnt_q[p]     <= '0;
      end
      drop_q     <= '0;
      st_q       <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
      rd_port_q  <= '0;
      rd_vld_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_pkt_q    <= '0;
      o_inport_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wptr_q[p]    <= wptr_d[p];
        commit_q[p]  <= commit_d[p];
        rptr_q[p]    <= rptr_d[p];
        pkt_num_q[p] <= pkt_num_d[p];
        wst_q[p]     <= wst_d[p];
        cnt_q[p]     <= cnt_d[p];
      end
      drop_q     <= drop_d;
      st_q       <= st_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      rd_port_q  <= rd_port_d;
      rd_vld_q   <= rd_vld_d;
      o_valid_q  <= o_valid_d;
      o_pkt_q    <= o_pkt_d;
      o_inport_q <= o_inport_d;
    end
  end

  assign o_pkt_valid = o_valid_q;
  assign o_pkt       = o_pkt_q;
  assign o_inport    = o_inport_q;
  assign o_drop      = drop_q;

endmodule
